// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with byte-serial run-time loader and 0-latency fetch port
//
// Purpose: serves 32-bit instruction words to the CPU fetch port combinationally,
// with contents packed big-endian from a byte-serial valid/ready load stream.
// Optional feature macro: INST_ROM_LOADER_CKSUM_EN (adds cksum_o, XOR of written words).
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ce_i, addr_i      fetch enable and byte address from core
//   inst_o            instruction word, 32'h0 when not a valid fetch
//   ld_start_i        begin/restart a load
//   ld_valid_i/ld_data_i/ld_last_i/ld_ready_o  byte load handshake
//   loaded_o          image complete, fetch enabled
//   ld_words_o        words written in current load
//   ld_err_o          sticky: image exceeded depth
//   cksum_o           (INST_ROM_LOADER_CKSUM_EN only) XOR of words written
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              loaded_o,
    output logic [ADDR_W:0]   ld_words_o,
    output logic              ld_err_o
`ifdef INST_ROM_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum_o
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
`ifdef INST_ROM_LOADER_CKSUM_EN
    logic [31:0]       cksum_q, cksum_d;
`endif

    logic [31:0]       mem_q [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              xfer;
    logic [31:0]       merged;

    assign xfer = ld_valid_i & ready_q;
    // Unfilled byte lanes of word_q are always zero, so OR-ing the new byte in
    // also yields the zero-padded word when the image ends mid-word.
    assign merged = word_q | ({ld_data_i, 24'h0} >> {cnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef INST_ROM_LOADER_CKSUM_EN
        cksum_d = cksum_q;
`endif
        we      = 1'b0;
        waddr   = words_q[ADDR_W-1:0];
        wdata   = merged;

        if (ld_start_i) begin
            // Restart from any state; a byte handshaking in this cycle is dropped.
            state_d = S_LOAD;
            words_d = '0;
            err_d   = 1'b0;
            cnt_d   = 2'd0;
            word_d  = 32'h0;
`ifdef INST_ROM_LOADER_CKSUM_EN
            cksum_d = 32'h0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (xfer) begin
                        if (words_q[ADDR_W]) begin
                            // Memory full: swallow the byte and flag overflow.
                            err_d = 1'b1;
                        end else if (cnt_q == 2'd3 || ld_last_i) begin
                            we      = 1'b1;
                            words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
                            cnt_d   = 2'd0;
                            word_d  = 32'h0;
`ifdef INST_ROM_LOADER_CKSUM_EN
                            cksum_d = cksum_q ^ merged;
`endif
                        end else begin
                            cnt_d  = cnt_q + 2'd1;
                            word_d = merged;
                        end
                        if (ld_last_i) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Ready is registered from the next state so it never depends on ld_valid_i.
    assign ready_d = (state_d == S_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            words_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0;
`ifdef INST_ROM_LOADER_CKSUM_EN
            cksum_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            words_q <= words_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef INST_ROM_LOADER_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              unused_addr_bits;

    assign idx              = addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^addr_i[1:0];
    // Reads gate on words_q, so stale contents from an earlier image never leak.
    assign hit    = ce_i && (state_q == S_DONE) && (addr_i[31:ADDR_W+2] == '0)
                    && ({1'b0, idx} < words_q);
    assign inst_o = hit ? mem_q[idx] : 32'h0;

    assign ld_ready_o = ready_q;
    assign loaded_o   = (state_q == S_DONE);
    assign ld_words_o = words_q;
    assign ld_err_o   = err_q;
`ifdef INST_ROM_LOADER_CKSUM_EN
    assign cksum_o    = cksum_q;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - randomized self-checking bench for inst_rom_loader (ADDR_W=10 and ADDR_W=2)
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        ld_start_i = 1'b0;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_data_i = 8'h0;
    logic        ld_last_i = 1'b0;

    logic [31:0] inst_a, inst_b;
    logic        ready_a, ready_b, loaded_a, loaded_b, err_a, err_b;
    logic [10:0] words_a;
    logic [2:0]  words_b;
`ifdef INST_ROM_LOADER_CKSUM_EN
    logic [31:0] cksum_a, cksum_b;
`endif

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_a),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_last_i(ld_last_i), .ld_ready_o(ready_a), .loaded_o(loaded_a),
        .ld_words_o(words_a), .ld_err_o(err_a)
`ifdef INST_ROM_LOADER_CKSUM_EN
        , .cksum_o(cksum_a)
`endif
    );

    inst_rom_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_b),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_last_i(ld_last_i), .ld_ready_o(ready_b), .loaded_o(loaded_b),
        .ld_words_o(words_b), .ld_err_o(err_b)
`ifdef INST_ROM_LOADER_CKSUM_EN
        , .cksum_o(cksum_b)
    `endif
    );

    // Reference model: the bytes accepted since the last start, plus phase flags.
    logic [7:0] mb[$];
    bit         m_done    = 1'b0;
    bit         m_loading = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_words(input int depth);
        int w;
        w = m_done ? (mb.size() + 3) / 4 : mb.size() / 4;
        return (w > depth) ? depth : w;
    endfunction

    function automatic logic [31:0] m_word(input int i);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++)
            if (4 * i + k < mb.size()) w[31-8*k -: 8] = mb[4*i+k];
        return w;
    endfunction

    function automatic logic [31:0] m_fetch(input int depth, input int aw, input bit ce,
                                            input logic [31:0] addr);
        int idx;
        if (!(ce && m_done)) return 32'h0;
        if ((addr >> (aw + 2)) != 0) return 32'h0;
        idx = int'(addr >> 2);
        if (idx >= m_words(depth)) return 32'h0;
        return m_word(idx);
    endfunction

    function automatic logic [31:0] m_cksum(input int depth);
        logic [31:0] c = 32'h0;
        for (int i = 0; i < m_words(depth); i++) c ^= m_word(i);
        return c;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".loaded_a"}, 32'(loaded_a), 32'(m_done));
        check({tag, ".loaded_b"}, 32'(loaded_b), 32'(m_done));
        check({tag, ".words_a"}, 32'(words_a), 32'(m_words(1024)));
        check({tag, ".words_b"}, 32'(words_b), 32'(m_words(4)));
        check({tag, ".err_a"}, 32'(err_a), 32'(mb.size() > 4096));
        check({tag, ".err_b"}, 32'(err_b), 32'(mb.size() > 16));
        check({tag, ".ready_a"}, 32'(ready_a), 32'(m_loading && !m_done));
        check({tag, ".ready_b"}, 32'(ready_b), 32'(m_loading && !m_done));
`ifdef INST_ROM_LOADER_CKSUM_EN
        if (m_done) begin
            check({tag, ".cksum_a"}, cksum_a, m_cksum(1024));
            check({tag, ".cksum_b"}, cksum_b, m_cksum(4));
        end
`endif
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic fetch(input logic [31:0] addr, input bit ce);
        ce_i = ce;
        addr_i = addr;
        #2;
        check($sformatf("fetch_a@%h", addr), inst_a, m_fetch(1024, 10, ce, addr));
        check($sformatf("fetch_b@%h", addr), inst_b, m_fetch(4, 2, ce, addr));
        @(posedge clk); #1;
    endtask

    task automatic start(input bit junk);
        ld_start_i = 1'b1;
        if (junk) begin
            ld_valid_i = 1'b1;
            ld_data_i = 8'($urandom);
        end
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        mb.delete();
        m_done = 1'b0;
        m_loading = 1'b1;
        check("start.loaded_a", 32'(loaded_a), 32'h0);
        check("start.words_a", 32'(words_a), 32'h0);
        @(posedge clk); #1;
        check_status("start");
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int guard = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        ld_valid_i = 1'b1;
        ld_data_i = b;
        ld_last_i = last;
        while (!ready_a && guard < 8) begin @(posedge clk); #1; guard++; end
        if (!ready_a) begin
            check("ready_timeout", 32'(ready_a), 32'h1);
            ld_valid_i = 1'b0;
            ld_last_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ld_valid_i = 1'b0;
        ld_last_i = 1'b0;
        mb.push_back(b);
        if (last) m_done = 1'b1;
        check_status("byte");
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        ce_i = 1'b1;
        addr_i = 32'h0;
        #1;
        check("rst.inst_a", inst_a, 32'h0);
        check_status("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed two-word image
        start(1'b0);
        send_byte(8'h24, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h34, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h06, 1);
        check("dir.words", 32'(words_a), 32'd2);
        check("dir.loaded", 32'(loaded_a), 32'd1);
        ce_i = 1'b1; addr_i = 32'h0; #1;
        check("dir.addr0", inst_a, 32'h24010005);
        addr_i = 32'h5; #1;
        check("dir.addr5", inst_a, 32'h34020006);
        @(posedge clk); #1;
        fetch(32'h0, 1); fetch(32'h4, 1); fetch(32'h8, 1); fetch(32'h5, 1);

        // Partial final word, zero padded
        start(1'b0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        send_byte(8'hDD, 0); send_byte(8'hEE, 1);
        ce_i = 1'b1; addr_i = 32'h4; #1;
        check("pad.addr4", inst_a, 32'hEE000000);
`ifdef INST_ROM_LOADER_CKSUM_EN
        check("pad.cksum", cksum_a, 32'h44BBCCDD);
`endif
        @(posedge clk); #1;
        fetch(32'h4, 1);

        // Overflow on the 4-word instance
        start(1'b0);
        send_n(17);
        check("ovf.err_b", 32'(err_b), 32'd1);
        check("ovf.words_b", 32'(words_b), 32'd4);
        fetch(32'h10, 1); fetch(32'hC, 1);

        // Restart mid-load, junk byte in the restart cycle is dropped
        start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        start(1'b1);
        send_n(4);
        fetch(32'h0, 1);

        // ce_i low, then restart after DONE
        fetch(32'h0, 0);
        start(1'b0);
        fetch(32'h0, 1);
        send_byte(8'h11, 0);
        fetch(32'h0, 1);

        // Asynchronous reset mid-load
        #1;
        rst = 1'b0;
        #1;
        mb.delete();
        m_done = 1'b0;
        m_loading = 1'b0;
        check_status("arst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        fetch(32'h0, 1);

        // Randomized images and fetches
        for (int it = 0; it < 12; it++) begin
            start($urandom_range(0, 1) == 1);
            send_n($urandom_range(1, 24));
            for (int f = 0; f < 6; f++) begin
                logic [31:0] a;
                a = {25'h0, 3'($urandom), 2'($urandom)} << 0;
                a = a << 0;
                a[4:2] = 3'($urandom);
                if ($urandom_range(0, 7) == 0) a[31 - $urandom_range(0, 19)] = 1'b1;
                fetch(a, $urandom_range(0, 5) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-ROM responder for the CPU fetch interface: the core drives ce/addr, and this block returns the 32-bit instruction word combinationally in the same cycle.
- Contents are filled at run time through a byte-serial valid/ready load port. A 3-state FSM packs bytes big-endian (MIPS order) into words and writes them sequentially.
- Sits beside the CPU core at SoC top; the load port connects to a UART/debug loader.

Parameters:
ADDR_W, 10, word-address width; depth = 2**ADDR_W words (4 KiB default)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ce_i  in  1  fetch enable from core
addr_i  in  32  byte fetch address from core
inst_o  out  32  instruction word to core
ld_start_i  in  1  pulse: begin/restart a load
ld_valid_i  in  1  load byte valid
ld_data_i  in  8  load byte
ld_last_i  in  1  qualifies final byte of image (valid with ld_valid_i)
ld_ready_o  out  1  block accepts a byte this cycle
loaded_o  out  1  image complete; fetch enabled
ld_words_o  out  ADDR_W+1  number of words written
ld_err_o  out  1  sticky overflow: image exceeded depth

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ld_ready_o=0, loaded_o=0, ld_words_o=0, ld_err_o=0, byte count=0, word shift reg=0. Memory array not reset.
- Reset mid-load aborts the load: all words are treated as unwritten.
- Byte transfer occurs when ld_valid_i & ld_ready_o at a rising edge.
- FSM IDLE:
  - ld_ready_o=0; bytes ignored.
  - ld_start_i -> LOAD; clears ld_words_o, ld_err_o, byte count and shift reg; loaded_o=0.
- FSM LOAD:
  - ld_ready_o=1 (registered; becomes 1 the cycle after entry).
  - Byte k (k=0..3) of a word goes to bits [31-8k:24-8k].
  - 4th byte: word written to mem[ld_words_o]; ld_words_o increments on the same edge.
  - Transfer with ld_last_i and partial word: unfilled low bytes are zero; word written; -> DONE.
  - Transfer with ld_last_i on a word boundary (4th byte): normal write; -> DONE.
  - Full (ld_words_o == 2**ADDR_W): further bytes accepted and discarded; ld_err_o set; ld_last_i still -> DONE.
  - ld_start_i in LOAD: restart (same clears as in IDLE); stays in LOAD; a byte in that cycle is discarded.
- FSM DONE:
  - loaded_o=1, ld_ready_o=0.
  - ld_start_i -> LOAD; loaded_o drops on the same edge.
- Fetch read (combinational; 0-cycle latency, matching core's expectation):
  - idx = addr_i[ADDR_W+1:2]; addr_i[1:0] ignored.
  - inst_o = mem[idx] when ce_i=1, loaded_o=1, addr_i[31:ADDR_W+2]==0 and idx < ld_words_o.
  - Otherwise inst_o = 32'h0 (NOP).
- Simultaneous load write and fetch of the same index: fetch returns 0 because loaded_o=0 during LOAD; no read-during-write hazard.

Optional Feature:
INST_ROM_LOADER_CKSUM_EN:
- Defined: adds output cksum_o[31:0].
  - XOR of all words written in the current load, including a zero-padded final word.
  - Cleared on reset and on ld_start_i; updates on the write edge; valid while loaded_o=1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with rst=0, then release; ce_i=1, addr_i=0 -> inst_o=0, loaded_o=0, ld_ready_o=0, ld_words_o=0.
- ld_start_i pulse; bytes 24,01,00,05 then 34,02,00,06 with ld_last_i on the final byte -> ld_words_o=2, loaded_o=1. Fetch addr 0 -> 32'h24010005; addr 4 -> 32'h34020006; addr 8 -> 0; addr 5 -> 32'h34020006.
- Load 5 bytes AA,BB,CC,DD,EE with ld_last_i on EE -> ld_words_o=2; addr 4 reads 32'hEE000000. With CKSUM_EN, cksum_o=32'h44BBCCDD.
- ADDR_W=2: load 17 bytes with last on byte 17 -> ld_words_o=4, ld_err_o=1, loaded_o=1; addr 16 -> 0 (out of range).
- Mid-load (after 6 bytes): ld_start_i -> ld_words_o=0, next 4 bytes land at index 0. Separately, asserting rst=0 mid-load -> IDLE, loaded_o=0, fetch returns 0.
- After a DONE load: ce_i=0 -> inst_o=0. ld_start_i again -> loaded_o=0 on the next edge and fetch returns 0 until the new load completes.
